lvds_cnt_checker: RTL and testbench

//  Receive-side checker for the 5-lane LVDS loopback test. The far-end transmitter drives a 5-bit

---
 rtl/lvds_tst_pkg.sv | 17 +
 rtl/lvds_win_timer.sv | 24 ++
 rtl/lvds_cnt_checker.sv | 180 ++++++++++++++++++
 tb/tb_lvds_cnt_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tst_pkg.sv
// Shared types and helpers for the LVDS loopback test logic.
package lvds_tst_pkg;

  localparam int unsigned LVDS_LANES = 5;

  typedef enum logic [1:0] {HUNT, CHK, LOCKED} lvds_chk_st_e;

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lvds_win_timer.sv
// Free-running window counter 0..WIN_CYC-1; win_last flags the final cycle of each window.
module lvds_win_timer #(
  parameter int unsigned WIN_CYC = 250_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic win_last
);

  localparam int unsigned CW = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    win_last = (cnt_q == CW'(WIN_CYC - 1));
    cnt_d    = win_last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lvds_cnt_checker.sv
// Locks to the far-end incrementing lane counter and accumulates word/bit error
// statistics per fixed window, latching them for the register bus.
module lvds_cnt_checker
  import lvds_tst_pkg::*;
#(
  parameter int unsigned LANES    = LVDS_LANES,
  parameter int unsigned WIN_CYC  = 250_000_000,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 8
) (
  input  logic             CLK_250M,
  input  logic             RST,
  input  logic [LANES-1:0] LANE_DATA,
  input  logic             ERR_CLR,
  output logic             LOCKED,
  output logic             WIN_TICK,
  output logic [31:0]      WORD_ERR_LAT,
  output logic [31:0]      BIT_ERR_LAT,
  output logic [LANES-1:0] LANE_ERR_LAT,
  output logic [LANES-1:0] STICKY_ERR
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);
  localparam int unsigned CHUNKS = (LANES + 4) / 5;
  localparam int unsigned PAD_W  = CHUNKS * 5;

  lvds_chk_st_e     state_q, state_d;
  logic [LANES-1:0] d_q, prev_q;
  logic [LANES-1:0] exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
  logic [31:0]      word_q, word_d, word_nxt;
  logic [31:0]      bit_q, bit_d, bit_nxt;
  logic [32:0]      bit_sum;
  logic [LANES-1:0] mask_q, mask_d, mask_nxt;
  logic [LANES-1:0] sticky_q, sticky_d;
  logic [31:0]      word_lat_q, word_lat_d;
  logic [31:0]      bit_lat_q, bit_lat_d;
  logic [LANES-1:0] lane_lat_q, lane_lat_d;
  logic             tick_q, tick_d;
  logic             locked_q, locked_d;
  logic             good;
  logic             win_last;
  logic [LANES-1:0] err_vec;
  logic [PAD_W-1:0] diff_pad;
  logic [31:0]      pop;

  lvds_win_timer #(.WIN_CYC(WIN_CYC)) u_win_timer (
    .clk      (CLK_250M),
    .rst      (RST),
    .win_last (win_last)
  );

  // Error vector and its popcount, summed five lanes at a time.
  always_comb begin
    err_vec  = (state_q == lvds_tst_pkg::LOCKED) ? (d_q ^ exp_q) : '0;
    diff_pad = PAD_W'(err_vec);
    pop      = '0;
    for (int unsigned c = 0; c < CHUNKS; c++) begin
      pop = pop + 32'(popcnt5(diff_pad[c*5 +: 5]));
    end
  end

  always_comb begin
    good    = (d_q == prev_q + LANES'(1));
    run_inc = run_q + RUN_W'(1);
    bad_inc = bad_q + BAD_W'(1);
    state_d = state_q;
    run_d   = run_q;
    bad_d   = bad_q;
    exp_d   = exp_q;
    unique case (state_q)
      lvds_tst_pkg::HUNT: begin
        if (good) begin
          run_d = RUN_W'(1);
          if (LOCK_CNT <= 1) begin
            state_d = lvds_tst_pkg::LOCKED;
            exp_d   = d_q + LANES'(1);
            bad_d   = '0;
          end else begin
            state_d = lvds_tst_pkg::CHK;
          end
        end
      end
      lvds_tst_pkg::CHK: begin
        if (good) begin
          run_d = run_inc;
          if (run_inc == RUN_W'(LOCK_CNT)) begin
            state_d = lvds_tst_pkg::LOCKED;
            exp_d   = d_q + LANES'(1);
            bad_d   = '0;
          end
        end else begin
          state_d = lvds_tst_pkg::HUNT;
          run_d   = '0;
        end
      end
      lvds_tst_pkg::LOCKED: begin
        // Expected word free-runs; a mismatch never re-syncs it.
        exp_d = exp_q + LANES'(1);
        if (err_vec == '0) begin
          bad_d = '0;
        end else begin
          bad_d = bad_inc;
          if (bad_inc == BAD_W'(LOSS_CNT)) begin
            state_d = lvds_tst_pkg::HUNT;
            run_d   = '0;
          end
        end
      end
      default: begin
        state_d = lvds_tst_pkg::HUNT;
        run_d   = '0;
      end
    endcase

    word_nxt = ((err_vec != '0) && (word_q != '1)) ? word_q + 32'd1 : word_q;
    bit_sum  = {1'b0, bit_q} + {1'b0, pop};
    bit_nxt  = bit_sum[32] ? '1 : bit_sum[31:0];
    mask_nxt = mask_q | err_vec;
    sticky_d = (ERR_CLR ? '0 : sticky_q) | err_vec;

    // The closing cycle's own error goes into the latch, not the next window.
    word_d     = win_last ? '0       : word_nxt;
    bit_d      = win_last ? '0       : bit_nxt;
    mask_d     = win_last ? '0       : mask_nxt;
    word_lat_d = win_last ? word_nxt : word_lat_q;
    bit_lat_d  = win_last ? bit_nxt  : bit_lat_q;
    lane_lat_d = win_last ? mask_nxt : lane_lat_q;
    tick_d     = win_last;
    locked_d   = (state_d == lvds_tst_pkg::LOCKED);
  end

  always_ff @(posedge CLK_250M) begin
    if (RST) begin
      state_q    <= lvds_tst_pkg::HUNT;
      d_q        <= '0;
      prev_q     <= '0;
      exp_q      <= '0;
      run_q      <= '0;
      bad_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      mask_q     <= '0;
      sticky_q   <= '0;
      word_lat_q <= '0;
      bit_lat_q  <= '0;
      lane_lat_q <= '0;
      tick_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= LANE_DATA;
      prev_q     <= d_q;
      exp_q      <= exp_d;
      run_q      <= run_d;
      bad_q      <= bad_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      word_lat_q <= word_lat_d;
      bit_lat_q  <= bit_lat_d;
      lane_lat_q <= lane_lat_d;
      tick_q     <= tick_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    LOCKED       = locked_q;
    WIN_TICK     = tick_q;
    WORD_ERR_LAT = word_lat_q;
    BIT_ERR_LAT  = bit_lat_q;
    LANE_ERR_LAT = lane_lat_q;
    STICKY_ERR   = sticky_q;
  end

endmodule

// File: tb/tb_lvds_cnt_checker.sv
// Scenario and randomized checks of lvds_cnt_checker against a behavioural window/lock model.
module tb_lvds_cnt_checker;

  localparam int WIN  = 100;
  localparam int LCK  = 4;
  localparam int LOSS = 3;
  localparam int M_HUNT = 0, M_CHK = 1, M_LOCK = 2;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  lane_data = '0;
  logic        err_clr = 1'b0;
  logic        locked, win_tick;
  logic [31:0] word_err_lat, bit_err_lat;
  logic [4:0]  lane_err_lat, sticky_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit [4:0] pat;

  always #5 clk = ~clk;

  lvds_cnt_checker #(
    .LANES(5), .WIN_CYC(WIN), .LOCK_CNT(LCK), .LOSS_CNT(LOSS)
  ) dut (
    .CLK_250M     (clk),
    .RST          (rst),
    .LANE_DATA    (lane_data),
    .ERR_CLR      (err_clr),
    .LOCKED       (locked),
    .WIN_TICK     (win_tick),
    .WORD_ERR_LAT (word_err_lat),
    .BIT_ERR_LAT  (bit_err_lat),
    .LANE_ERR_LAT (lane_err_lat),
    .STICKY_ERR   (sticky_err)
  );

  // Reference model: words enter a two-deep history; lock/loss by streak counting.
  int       m_mode, m_run, m_bad, m_timer;
  bit [4:0] m_d, m_prev, m_exp, m_sticky, m_mask, m_lmask, x;
  longint   m_word, m_bits, m_lword, m_lbits;
  bit       m_tick, m_locked, good;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_HUNT; m_run = 0; m_bad = 0; m_timer = 0;
      m_d = 0; m_prev = 0; m_exp = 0; m_sticky = 0; m_mask = 0; m_lmask = 0;
      m_word = 0; m_bits = 0; m_lword = 0; m_lbits = 0; m_tick = 0; m_locked = 0;
    end else begin
      x = 5'b0;
      good = ((((int'(m_d) - int'(m_prev)) % 32) + 32) % 32) == 1;
      if (m_mode == M_LOCK) begin
        x = m_d ^ m_exp;
        m_exp = m_exp + 5'd1;
        if (x == 0) m_bad = 0;
        else begin
          m_bad++;
          m_word = (m_word + 1 > SAT) ? SAT : m_word + 1;
          m_bits = (m_bits + $countones(x) > SAT) ? SAT : m_bits + $countones(x);
          m_mask |= x;
          if (m_bad == LOSS) begin m_mode = M_HUNT; m_run = 0; end
        end
      end else if (good) begin
        m_run = (m_mode == M_HUNT) ? 1 : m_run + 1;
        m_mode = M_CHK;
        if (m_run >= LCK) begin m_mode = M_LOCK; m_exp = m_d + 5'd1; m_bad = 0; end
      end else begin
        m_mode = M_HUNT; m_run = 0;
      end
      m_sticky = (err_clr ? 5'b0 : m_sticky) | x;
      m_tick = (m_timer == WIN - 1);
      if (m_tick) begin
        m_lword = m_word; m_lbits = m_bits; m_lmask = m_mask;
        m_word = 0; m_bits = 0; m_mask = 0; m_timer = 0;
      end else m_timer++;
      m_locked = (m_mode == M_LOCK);
      m_prev = m_d;
      m_d = lane_data;
    end
  end

  task automatic cyc(input bit [4:0] w, input bit clr);
    @(negedge clk);
    lane_data = w;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pat_cyc(input bit [4:0] flip, input bit clr);
    cyc(pat ^ flip, clr);
    pat = pat + 5'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) cyc(5'($urandom), 1'b0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    n_cmp++; if (win_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %0b expected 0", win_tick); end
    n_cmp++; if (word_err_lat !== 32'd0) begin n_bad++; $display("FAIL rst_word: got %0h expected 0", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd0) begin n_bad++; $display("FAIL rst_bit: got %0h expected 0", bit_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'd0) begin n_bad++; $display("FAIL rst_lane: got %0h expected 0", lane_err_lat); end
    n_cmp++; if (sticky_err !== 5'd0) begin n_bad++; $display("FAIL rst_sticky: got %0h expected 0", sticky_err); end
  endtask

  task automatic test_lock_first_window;
    rst = 1'b0;
    pat = 5'd0;
    for (int k = 1; k <= WIN; k++) begin
      pat_cyc(5'd0, 1'b0);
      n_cmp++; if (locked !== (k >= 6)) begin n_bad++; $display("FAIL lock_rise k=%0d: got %0b expected %0b", k, locked, k >= 6); end
      n_cmp++; if (win_tick !== (k == WIN)) begin n_bad++; $display("FAIL first_tick k=%0d: got %0b expected %0b", k, win_tick, k == WIN); end
    end
    n_cmp++; if (word_err_lat !== 32'd0) begin n_bad++; $display("FAIL clean_word: got %0d expected 0", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd0) begin n_bad++; $display("FAIL clean_bit: got %0d expected 0", bit_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'd0) begin n_bad++; $display("FAIL clean_lane: got %0h expected 0", lane_err_lat); end
  endtask

  task automatic test_single_error;
    for (int k = 1; k <= WIN; k++) begin
      pat_cyc((k == 10) ? 5'b00101 : 5'b0, 1'b0);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked k=%0d: got %0b expected 1", k, locked); end
      if (k == 11) begin
        n_cmp++; if (sticky_err !== 5'b00101) begin n_bad++; $display("FAIL single_sticky: got %05b expected 00101", sticky_err); end
      end
    end
    n_cmp++; if (win_tick !== 1'b1) begin n_bad++; $display("FAIL single_tick: got %0b expected 1", win_tick); end
    n_cmp++; if (word_err_lat !== 32'd1) begin n_bad++; $display("FAIL single_word: got %0d expected 1", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd2) begin n_bad++; $display("FAIL single_bit: got %0d expected 2", bit_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'b00101) begin n_bad++; $display("FAIL single_lane: got %05b expected 00101", lane_err_lat); end
  endtask

  task automatic test_loss_relock;
    for (int k = 1; k <= WIN; k++) begin
      pat_cyc((k >= 5 && k <= 7) ? 5'h1F : 5'h0, 1'b0);
      n_cmp++; if (locked !== (k < 8 || k >= 13)) begin n_bad++; $display("FAIL loss_locked k=%0d: got %0b expected %0b", k, locked, (k < 8 || k >= 13)); end
    end
    n_cmp++; if (word_err_lat !== 32'd3) begin n_bad++; $display("FAIL loss_word: got %0d expected 3", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd15) begin n_bad++; $display("FAIL loss_bit: got %0d expected 15", bit_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'h1F) begin n_bad++; $display("FAIL loss_lane: got %05b expected 11111", lane_err_lat); end
  endtask

  task automatic test_window_boundary;
    for (int k = 1; k <= WIN; k++) pat_cyc((k == WIN - 1) ? 5'b00001 : 5'b0, 1'b0);
    n_cmp++; if (win_tick !== 1'b1) begin n_bad++; $display("FAIL edge_tick: got %0b expected 1", win_tick); end
    n_cmp++; if (word_err_lat !== 32'd1) begin n_bad++; $display("FAIL edge_word: got %0d expected 1", word_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'b00001) begin n_bad++; $display("FAIL edge_lane: got %05b expected 00001", lane_err_lat); end
    for (int k = 1; k <= WIN; k++) pat_cyc(5'b0, 1'b0);
    n_cmp++; if (word_err_lat !== 32'd0) begin n_bad++; $display("FAIL edge_next_word: got %0d expected 0", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd0) begin n_bad++; $display("FAIL edge_next_bit: got %0d expected 0", bit_err_lat); end
  endtask

  task automatic test_sticky_clr;
    n_cmp++; if (sticky_err !== 5'h1F) begin n_bad++; $display("FAIL sticky_pre: got %05b expected 11111", sticky_err); end
    pat_cyc(5'b10000, 1'b0);
    pat_cyc(5'b0, 1'b1);
    n_cmp++; if (sticky_err !== 5'b10000) begin n_bad++; $display("FAIL sticky_set_wins: got %05b expected 10000", sticky_err); end
    pat_cyc(5'b0, 1'b0);
    pat_cyc(5'b0, 1'b1);
    n_cmp++; if (sticky_err !== 5'b00000) begin n_bad++; $display("FAIL sticky_clear: got %05b expected 00000", sticky_err); end
    for (int k = 5; k <= WIN; k++) pat_cyc(5'b0, 1'b0);
    n_cmp++; if (word_err_lat !== 32'd1) begin n_bad++; $display("FAIL sticky_win_word: got %0d expected 1", word_err_lat); end
  endtask

  task automatic test_rst_mid_window;
    int e1, e2;
    e1 = $urandom_range(5, 20);
    e2 = $urandom_range(25, 45);
    for (int k = 1; k < 50; k++) pat_cyc((k == e1 || k == e2) ? 5'(($urandom_range(1, 31))) : 5'b0, 1'b0);
    n_cmp++; if (sticky_err === 5'b0) begin n_bad++; $display("FAIL rstmid_pre_sticky: got %05b expected nonzero", sticky_err); end
    rst = 1'b1;
    pat_cyc(5'b0, 1'b0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_locked: got %0b expected 0", locked); end
    n_cmp++; if (word_err_lat !== 32'd0) begin n_bad++; $display("FAIL rstmid_word: got %0d expected 0", word_err_lat); end
    n_cmp++; if (bit_err_lat !== 32'd0) begin n_bad++; $display("FAIL rstmid_bit: got %0d expected 0", bit_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'd0) begin n_bad++; $display("FAIL rstmid_lane: got %05b expected 0", lane_err_lat); end
    n_cmp++; if (sticky_err !== 5'd0) begin n_bad++; $display("FAIL rstmid_sticky: got %05b expected 0", sticky_err); end
    rst = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      cyc(5'h0A, 1'b0);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL const_locked k=%0d: got %0b expected 0", k, locked); end
      n_cmp++; if (win_tick !== (k == WIN)) begin n_bad++; $display("FAIL rst_tick k=%0d: got %0b expected %0b", k, win_tick, k == WIN); end
    end
    n_cmp++; if (word_err_lat !== 32'd0) begin n_bad++; $display("FAIL const_word: got %0d expected 0", word_err_lat); end
    n_cmp++; if (lane_err_lat !== 5'd0) begin n_bad++; $display("FAIL const_lane: got %05b expected 0", lane_err_lat); end
  endtask

  task automatic test_random;
    int r;
    bit [4:0] flip;
    pat = 5'($urandom);
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 199);
      flip = (r < 8) ? 5'($urandom_range(1, 31)) : 5'b0;
      if (r == 8) pat = 5'($urandom);
      rst = (r == 9);
      pat_cyc(flip, $urandom_range(0, 15) == 0);
      n_cmp++; if (locked !== m_locked) begin n_bad++; $display("FAIL rnd_locked k=%0d: got %0b expected %0b", k, locked, m_locked); end
      n_cmp++; if (win_tick !== m_tick) begin n_bad++; $display("FAIL rnd_tick k=%0d: got %0b expected %0b", k, win_tick, m_tick); end
      n_cmp++; if (word_err_lat !== 32'(m_lword)) begin n_bad++; $display("FAIL rnd_word k=%0d: got %0d expected %0d", k, word_err_lat, m_lword); end
      n_cmp++; if (bit_err_lat !== 32'(m_lbits)) begin n_bad++; $display("FAIL rnd_bit k=%0d: got %0d expected %0d", k, bit_err_lat, m_lbits); end
      n_cmp++; if (lane_err_lat !== m_lmask) begin n_bad++; $display("FAIL rnd_lane k=%0d: got %05b expected %05b", k, lane_err_lat, m_lmask); end
      n_cmp++; if (sticky_err !== m_sticky) begin n_bad++; $display("FAIL rnd_sticky k=%0d: got %05b expected %05b", k, sticky_err, m_sticky); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_first_window();
    test_single_error();
    test_loss_relock();
    test_window_boundary();
    test_sticky_clr();
    test_rst_mid_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
